// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the default operand width.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath. The accumulator holds
// {upper, lower} halves: for multiply {partial product, remaining multiplier},
// for divide {partial remainder, dividend bits / quotient bits}.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     opnd,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] part;
   logic [WIDTH:0] trial;

   // Shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      part  = acc[2*WIDTH-1:WIDTH-1];
      trial = part - {1'b0, opnd};
      if (!is_div) begin
         // Carry out of the add lands in the top bit as everything shifts right.
         acc_next = {sum, acc[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
         acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Magnitudes are iterated unsigned; signs are restored in the FIN cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q, done_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic [WIDTH-1:0]   mag_a_q, mag_b_q, orig_a_q;
   logic [2*WIDTH-1:0] acc_q, acc_next;
   logic               is_div_q, neg_q, neg_rem_q, dz_q;

   logic               md_start, mthi, mtlo, op_div, op_sgn;
   logic               sa, sb;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;

   function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] x);
      return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg_w(input logic signed [WIDTH-1:0] x,
                                                   input logic neg);
      return neg ? WIDTH'(-x) : WIDTH'(x);
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic signed [2*WIDTH-1:0] x,
                                                      input logic neg);
      return neg ? (2*WIDTH)'(-x) : (2*WIDTH)'(x);
   endfunction

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div_q),
      .acc      (acc_q),
      .opnd     (is_div_q ? mag_b_q : mag_a_q),
      .acc_next (acc_next)
   );

   // Request decode (IDLE only) and next-state logic.
   always_comb begin
      md_start = 1'b0;
      mthi     = 1'b0;
      mtlo     = 1'b0;
      op_div   = (op == OP_DIV) || (op == OP_DIVU);
      op_sgn   = (op == OP_MULT) || (op == OP_DIV);
      sa       = op_sgn & src_a[WIDTH-1];
      sb       = op_sgn & src_b[WIDTH-1];
      if (state_q == ST_IDLE && start) begin
         case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: md_start = 1'b1;
            OP_MTHI:                            mthi     = 1'b1;
            OP_MTLO:                            mtlo     = 1'b1;
            default:                            ;
         endcase
      end
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (md_start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sign fix-up of the final accumulator; divide by zero is forced explicitly.
   always_comb begin
      prod = cond_neg_2w(acc_q, neg_q);
      if (!is_div_q) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (dz_q) begin
         res_hi = orig_a_q;
         res_lo = '1;
      end else begin
         res_hi = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
         res_lo = cond_neg_w(acc_q[WIDTH-1:0], neg_q);
      end
   end

   // Control and architectural state; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == ST_FIN);
         if (md_start) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (state_q == ST_RUN) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (state_q == ST_FIN) begin
            busy_q <= 1'b0;
            hi_q   <= res_hi;
            lo_q   <= res_lo;
         end else begin
            if (mthi) hi_q <= src_a;
            if (mtlo) lo_q <= src_a;
         end
      end
   end

   // Operand latch at start, then one iteration per RUN cycle.
   always_ff @(posedge clk) begin
      if (md_start) begin
         mag_a_q   <= op_sgn ? abs_w(src_a) : src_a;
         mag_b_q   <= op_sgn ? abs_w(src_b) : src_b;
         orig_a_q  <= src_a;
         is_div_q  <= op_div;
         neg_q     <= sa ^ sb;
         neg_rem_q <= sa;
         dz_q      <= op_div && (src_b == '0);
         acc_q     <= {{WIDTH{1'b0}}, (op_div ? (op_sgn ? abs_w(src_a) : src_a)
                                              : (op_sgn ? abs_w(src_b) : src_b))};
      end else if (state_q == ST_RUN) begin
         acc_q <= acc_next;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency,
// busy/done handshake, MTHI/MTLO, ignored requests and asynchronous reset.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_vec = 0;
   int n_err = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue a MUL/DIV now (called #1 after an edge), then follow it to completion.
   task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int busy_cnt;
      start = 1'b1; op = o; src_a = a; src_b = b;
      tick();
      start = 1'b0;
      chk({tag, "_done_low_at_start"}, {31'd0, done}, 32'd0);
      busy_cnt = 0;
      while (busy && busy_cnt < 40) begin
         busy_cnt++;
         tick();
      end
      chk({tag, "_busy_cycles"}, busy_cnt, 32'd33);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int cyc;
      rst = 1'b0; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
      #3;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // 1: signed multiply, negative result
      run_md("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      tick();
      chk("mult_neg_done_drop", {31'd0, done}, 32'd0);
      chk("mult_neg_hold_lo", lo, 32'hFFFF_FFEB);

      // 2: unsigned multiply then back-to-back unsigned divide
      run_md("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_md("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);

      // 3: signed divide, truncating, and the overflow corner
      run_md("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      run_md("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

      // 4: divide by zero
      run_md("divu_by0", 3'b011, 32'h64, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
      run_md("div_by0_neg", 3'b010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

      // 5: MTHI/MTLO on consecutive cycles
      tick();
      start = 1'b1; op = 3'b100; src_a = 32'h1234_5678;
      tick();
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      op = 3'b101; src_a = 32'h9ABC_DEF0;
      tick();
      start = 1'b0;
      chk("mtlo_lo", lo, 32'h9ABC_DEF0);
      chk("mtlo_hi_held", hi, 32'h1234_5678);
      chk("mtlo_done", {31'd0, done}, 32'd0);

      // undefined op is a no-op
      start = 1'b1; op = 3'b110; src_a = 32'hAAAA_AAAA; src_b = 32'h5555_5555;
      tick();
      start = 1'b0;
      chk("undef_busy", {31'd0, busy}, 32'd0);
      chk("undef_hi", hi, 32'h1234_5678);
      chk("undef_lo", lo, 32'h9ABC_DEF0);

      // MULT with an MTHI issued mid-run
      start = 1'b1; op = 3'b000; src_a = 32'h0001_0000; src_b = 32'h0001_0000;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      start = 1'b1; op = 3'b100; src_a = 32'hDEAD_BEEF;
      tick();
      start = 1'b0;
      chk("mthi_midrun_ignored", hi, 32'h1234_5678);
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         tick();
      end
      chk("midrun_done", {31'd0, done}, 32'd1);
      chk("midrun_hi", hi, 32'h0000_0001);
      chk("midrun_lo", lo, 32'h0000_0000);

      // 6: asynchronous reset aborts a divide
      tick();
      start = 1'b1; op = 3'b010; src_a = 32'd100; src_b = 32'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      #1 rst = 1'b0;
      #1;
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      tick();
      #1 rst = 1'b1;
      tick();
      chk("abort_stays_idle", {31'd0, busy}, 32'd0);
      run_md("multu_3_5", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
